// File: rtl/queue_fifo_pkg.sv
// Shared sizing constants for the queue FIFO slice.
// Depth is always a power of two derived from the address width.
package queue_fifo_pkg;

  localparam int QF_WIDTH  = 8;
  localparam int QF_ADDR_W = 4;

  function automatic int qf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/queue_fifo_counter.sv
// Wrapping enable counter used for the FIFO read and write pointers.
// Rolls over naturally at 2**W, giving modulo-depth addressing.
module queue_fifo_counter
  import queue_fifo_pkg::*;
#(
  parameter int W = QF_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         encnt,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (init)
      cnt <= '0;
    else if (encnt)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/queue_fifo.sv
// Synchronous FIFO with occupancy count, threshold flags, sticky errors
// and a choice of registered or first-word fall-through read port.
module queue_fifo
  import queue_fifo_pkg::*;
#(
  parameter int WIDTH    = QF_WIDTH,
  parameter int ADDR_W   = QF_ADDR_W,
  parameter int AF_LEVEL = qf_depth(ADDR_W) - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int DEPTH = qf_depth(ADDR_W);
  localparam int CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_acc;
  logic              pop_acc;

  // Flags come only from the registered count.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  // A pop frees the slot, so a push into a full queue is still taken.
  assign pop_acc  = pop && !empty && !init;
  assign push_acc = push && (!full || pop_acc) && !init;

  queue_fifo_counter #(.W(ADDR_W)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .init  (init),
    .encnt (push_acc),
    .cnt   (wr_ptr)
  );

  queue_fifo_counter #(.W(ADDR_W)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .init  (init),
    .encnt (pop_acc),
    .cnt   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push_acc && !rst)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (init) begin
      count <= '0;
    end else begin
      unique case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else if (init) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (push && !push_acc)
        ovf_err <= 1'b1;
      if (pop && empty)
        udf_err <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out   = mem[rd_ptr];
      assign data_valid = !empty;
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out   <= '0;
          data_valid <= 1'b0;
        end else if (init) begin
          data_valid <= 1'b0;
        end else begin
          data_valid <= pop_acc;
          if (pop_acc)
            data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_queue_fifo.sv
// Directed vector bench for queue_fifo: registered and FWFT instances
// driven with the same stimulus, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_queue_fifo;

  localparam int W  = 8;
  localparam int AW = 2;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [W-1:0]  data_in = '0;

  logic [W-1:0]  r_dout, f_dout;
  logic          r_dv, f_dv;
  logic          r_full, f_full;
  logic          r_empty, f_empty;
  logic          r_af, f_af;
  logic          r_ae, f_ae;
  logic [AW:0]   r_cnt, f_cnt;
  logic          r_ovf, f_ovf;
  logic          r_udf, f_udf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  queue_fifo #(
    .WIDTH(W), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
  ) u_reg (
    .clk(clk), .rst(rst), .init(init), .push(push), .pop(pop),
    .data_in(data_in), .data_out(r_dout), .data_valid(r_dv),
    .full(r_full), .empty(r_empty), .almost_full(r_af),
    .almost_empty(r_ae), .count(r_cnt), .ovf_err(r_ovf), .udf_err(r_udf)
  );

  queue_fifo #(
    .WIDTH(W), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
  ) u_fw (
    .clk(clk), .rst(rst), .init(init), .push(push), .pop(pop),
    .data_in(data_in), .data_out(f_dout), .data_valid(f_dv),
    .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_cnt), .ovf_err(f_ovf), .udf_err(f_udf)
  );

  typedef struct {
    logic         push;
    logic         pop;
    logic         init;
    logic [W-1:0] din;
    int           cnt;
    logic [W-1:0] dout;
    logic         dv;
    logic         full;
    logic         empty;
    logic         af;
    logic         ae;
    logic         ovf;
    logic         udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic p, input logic q, input logic i,
                             input logic [W-1:0] din, input int c,
                             input logic [W-1:0] dout, input logic dv,
                             input logic ovf, input logic udf);
    vec_t t;
    t.push = p; t.pop = q; t.init = i; t.din = din;
    t.cnt = c; t.dout = dout; t.dv = dv;
    t.full = (c == D);
    t.empty = (c == 0);
    t.af = (c >= AF);
    t.ae = (c <= AE);
    t.ovf = ovf; t.udf = udf;
    return t;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic i,
                       input logic [W-1:0] d);
    @(negedge clk);
    push = p; pop = q; init = i; data_in = d;
  endtask

  initial begin
    // fill / drain
    vecs.push_back(v(1, 0, 0, 8'h11, 1, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 8'h22, 2, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 8'h33, 3, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 8'h44, 4, 8'h00, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h00, 3, 8'h11, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h00, 2, 8'h22, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h00, 1, 8'h33, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h00, 0, 8'h44, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 8'h00, 0, 8'h44, 0, 0, 0));
    // overflow, then push+pop while full
    vecs.push_back(v(1, 0, 0, 8'h11, 1, 8'h44, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 8'h22, 2, 8'h44, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 8'h33, 3, 8'h44, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 8'h44, 4, 8'h44, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 8'h55, 4, 8'h44, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 8'h66, 4, 8'h11, 1, 1, 0));
    vecs.push_back(v(0, 1, 0, 8'h00, 3, 8'h22, 1, 1, 0));
    vecs.push_back(v(0, 1, 0, 8'h00, 2, 8'h33, 1, 1, 0));
    vecs.push_back(v(0, 1, 0, 8'h00, 1, 8'h44, 1, 1, 0));
    vecs.push_back(v(0, 1, 0, 8'h00, 0, 8'h66, 1, 1, 0));
    vecs.push_back(v(1, 0, 0, 8'h11, 1, 8'h66, 0, 1, 0));
    // init beats a concurrent push
    vecs.push_back(v(1, 0, 1, 8'h12, 0, 8'h66, 0, 0, 0));
    // push+pop while empty
    vecs.push_back(v(1, 1, 0, 8'h77, 1, 8'h66, 0, 0, 1));
    vecs.push_back(v(0, 1, 0, 8'h00, 0, 8'h77, 1, 0, 1));
    // pointer wrap and thresholds
    vecs.push_back(v(1, 0, 0, 8'hA1, 1, 8'h77, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 8'hA2, 2, 8'h77, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 8'hA3, 3, 8'h77, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 8'hA4, 3, 8'hA1, 1, 0, 1));
    vecs.push_back(v(1, 1, 0, 8'hA5, 3, 8'hA2, 1, 0, 1));
    vecs.push_back(v(0, 1, 0, 8'h00, 2, 8'hA3, 1, 0, 1));
    vecs.push_back(v(0, 1, 0, 8'h00, 1, 8'hA4, 1, 0, 1));
    vecs.push_back(v(0, 1, 0, 8'h00, 0, 8'hA5, 1, 0, 1));
    vecs.push_back(v(0, 1, 0, 8'h00, 0, 8'hA5, 0, 0, 1));

    // reset state, sampled while rst still high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 0, 32'(r_cnt), 0);
    chk("rst_empty", 0, 32'(r_empty), 1);
    chk("rst_ae", 0, 32'(r_ae), 1);
    chk("rst_full", 0, 32'(r_full), 0);
    chk("rst_af", 0, 32'(r_af), 0);
    chk("rst_dout", 0, 32'(r_dout), 0);
    chk("rst_dv", 0, 32'(r_dv), 0);
    chk("rst_ovf", 0, 32'(r_ovf), 0);
    chk("rst_udf", 0, 32'(r_udf), 0);
    chk("rst_fw_dv", 0, 32'(f_dv), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].push, vecs[k].pop, vecs[k].init, vecs[k].din);
      @(posedge clk);
      #1;
      chk("count", k, 32'(r_cnt), 32'(vecs[k].cnt));
      chk("dout", k, 32'(r_dout), 32'(vecs[k].dout));
      chk("dv", k, 32'(r_dv), 32'(vecs[k].dv));
      chk("full", k, 32'(r_full), 32'(vecs[k].full));
      chk("empty", k, 32'(r_empty), 32'(vecs[k].empty));
      chk("af", k, 32'(r_af), 32'(vecs[k].af));
      chk("ae", k, 32'(r_ae), 32'(vecs[k].ae));
      chk("ovf", k, 32'(r_ovf), 32'(vecs[k].ovf));
      chk("udf", k, 32'(r_udf), 32'(vecs[k].udf));
      chk("fw_count", k, 32'(f_cnt), 32'(vecs[k].cnt));
      chk("fw_dv", k, 32'(f_dv), 32'(!vecs[k].empty));
    end

    // first-word fall-through
    drive(1, 0, 0, 8'h99);
    @(posedge clk);
    #1;
    chk("fw_head", 0, 32'(f_dout), 32'h99);
    chk("fw_valid", 0, 32'(f_dv), 1);
    chk("reg_novalid", 0, 32'(r_dv), 0);
    drive(1, 0, 0, 8'h88);
    @(posedge clk);
    #1;
    chk("fw_head", 1, 32'(f_dout), 32'h99);
    chk("fw_count", 100, 32'(f_cnt), 2);
    drive(0, 1, 0, 8'h00);
    #1;
    chk("fw_prepop", 0, 32'(f_dout), 32'h99);
    @(posedge clk);
    #1;
    chk("fw_advance", 0, 32'(f_dout), 32'h88);
    chk("reg_pop", 0, 32'(r_dout), 32'h99);
    chk("reg_pop_dv", 0, 32'(r_dv), 1);

    // async reset between edges, with a push held during reset
    drive(1, 0, 0, 8'h5A);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", 0, 32'(r_empty), 1);
    chk("arst_count", 0, 32'(r_cnt), 0);
    chk("arst_dout", 0, 32'(r_dout), 0);
    chk("arst_fw_empty", 0, 32'(f_empty), 1);
    chk("arst_fw_dv", 0, 32'(f_dv), 0);
    chk("arst_udf", 0, 32'(r_udf), 0);
    @(posedge clk);
    #1;
    chk("arst_hold", 0, 32'(r_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    push = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_count", 0, 32'(r_cnt), 0);
    chk("post_rst_empty", 0, 32'(f_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
